// File: rtl/shared_mem_responder.sv
// Shared-memory responder: PCI-first arbitration onto one RAM port, one-entry FPGA defer buffer, flag word.
// Latency: RAM and flag reads both return 2 cycles after issue; writes produce no response.
// Backpressure: fpga_stall is high while an FPGA access is deferred; FPGA requests arriving then are dropped.
module shared_mem_responder #(
  parameter logic [20:0] FLAG_ADDR = 21'h07FFFE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_req,
  input  logic        FPGA_wr_en,
  input  logic [20:0] req_addr,
  input  logic [31:0] write_data,
  output logic [31:0] rd_data,
  output logic        rd_ready,
  output logic        fpga_stall,
  input  logic        flag_we,
  input  logic [31:0] out_flag,
  output logic [31:0] in_flag,
  input  logic        pci_wr_en,
  input  logic        pci_rd_en,
  input  logic [20:0] pci_req_addr,
  input  logic [31:0] pci_input_data,
  output logic [31:0] pci_rd_data,
  output logic        pci_rd_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        err_sticky
);

  typedef enum logic {IDLE, DEFER} state_t;

  typedef struct packed {
    logic        wr;
    logic [20:0] addr;
    logic [31:0] dat;
  } req_t;

  state_t      state, state_nxt;
  req_t        defer_q, fpga_sel;
  logic        pci_act, fpga_act;
  logic        issue_fpga, defer_load, fpga_drop;
  logic        pci_flag, fpga_flag;
  logic        pci_rd_issue, fpga_rd_issue;
  logic        pci_flag_wr, fpga_flag_wr;
  logic        flag_wen, flag_lost;
  logic [31:0] flag_q, flag_nxt;
  logic        s1_vld, s1_pci, s1_flag;
  logic [31:0] s1_fdat, ret_dat;
  logic        err_q;

  assign pci_act  = pci_wr_en | pci_rd_en;
  assign fpga_act = FPGA_wr_en | rd_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fpga_sel   = {FPGA_wr_en, req_addr, write_data};
    issue_fpga = 1'b0;
    defer_load = 1'b0;
    fpga_drop  = 1'b0;
    fpga_stall = 1'b0;
    case (state)
      IDLE: begin
        if (fpga_act) begin
          if (pci_act) begin
            defer_load = 1'b1;
            state_nxt  = DEFER;
          end else begin
            issue_fpga = 1'b1;
          end
        end
      end
      DEFER: begin
        fpga_stall = 1'b1;
        fpga_drop  = fpga_act;
        fpga_sel   = defer_q;
        if (!pci_act) begin
          issue_fpga = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          defer_q <= '0;
    else if (defer_load) defer_q <= {FPGA_wr_en, req_addr, write_data};
  end

  assign pci_flag      = (pci_req_addr == FLAG_ADDR);
  assign fpga_flag     = (fpga_sel.addr == FLAG_ADDR);
  assign pci_rd_issue  = pci_rd_en & ~pci_wr_en;
  assign fpga_rd_issue = issue_fpga & ~fpga_sel.wr;
  assign pci_flag_wr   = pci_wr_en & pci_flag;
  assign fpga_flag_wr  = issue_fpga & fpga_sel.wr & fpga_flag;

  // The flag word never reaches the RAM; mem_en is also held low through reset.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (pci_act) begin
      mem_en    = ~pci_flag;
      mem_we    = pci_wr_en & ~pci_flag;
      mem_addr  = pci_req_addr;
      mem_wdata = pci_input_data;
    end else if (issue_fpga) begin
      mem_en    = ~fpga_flag;
      mem_we    = fpga_sel.wr & ~fpga_flag;
      mem_addr  = fpga_sel.addr;
      mem_wdata = fpga_sel.dat;
    end
    mem_en = mem_en & rst_n;
    mem_we = mem_we & rst_n;
  end

  // Host beats flag_we, which beats an FPGA-side flag write; any loser is an FPGA-side write.
  always_comb begin
    flag_wen = pci_flag_wr | flag_we | fpga_flag_wr;
    flag_nxt = fpga_sel.dat;
    if (pci_flag_wr)  flag_nxt = pci_input_data;
    else if (flag_we) flag_nxt = out_flag;
    flag_lost = (pci_flag_wr & (flag_we | fpga_flag_wr)) | (flag_we & fpga_flag_wr);
  end

  assign ret_dat = s1_flag ? s1_fdat : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld       <= 1'b0;
      s1_pci       <= 1'b0;
      s1_flag      <= 1'b0;
      s1_fdat      <= '0;
      rd_ready     <= 1'b0;
      rd_data      <= '0;
      pci_rd_valid <= 1'b0;
      pci_rd_data  <= '0;
      flag_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      s1_vld       <= pci_rd_issue | fpga_rd_issue;
      s1_pci       <= pci_act;
      s1_flag      <= pci_act ? pci_flag : fpga_flag;
      s1_fdat      <= flag_q;
      rd_ready     <= s1_vld & ~s1_pci;
      pci_rd_valid <= s1_vld & s1_pci;
      if (s1_vld & ~s1_pci)     rd_data     <= ret_dat;
      if (s1_vld & s1_pci)      pci_rd_data <= ret_dat;
      if (flag_wen)             flag_q      <= flag_nxt;
      if (fpga_drop | flag_lost) err_q      <= 1'b1;
    end
  end

  assign in_flag    = flag_q;
  assign err_sticky = err_q;

endmodule
